router_req_gen: RTL and testbench



---
 rtl/router_pkg.sv | 19 +
 rtl/router_sat_cnt.sv | 20 ++
 rtl/router_req_gen.sv | 144 ++++++++++++++
 tb/tb_router_req_gen.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the router request generator.
package router_pkg;

  localparam int ROUTER_ADDR_W = 10;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DONE,
    WAIT_LOW,
    GAP
  } rtr_req_state_t;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/router_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module router_sat_cnt #(
  parameter int W = 16
) (
  input  logic         user_clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value
);

  // NOTE: sequential state is always written with non-blocking assignments.
  always_ff @(posedge user_clk) begin
    if (clr) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/router_req_gen.sv
// Issues 4-phase start/done requests to the router with timeout supervision.
// Optional macro ROUTER_REQ_AUTO_EN adds an internal destination-sweep command source.
module router_req_gen
  import router_pkg::*;
#(
  parameter int ADDR_W      = ROUTER_ADDR_W,
  parameter int TIMEOUT_CYC = 65535,
  parameter int GAP_CYC     = 4,
  parameter int CNT_W       = 16
) (
  input  logic              user_clk,
  input  logic              reset,
  input  logic              channel_up,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
`ifdef ROUTER_REQ_AUTO_EN
  input  logic              auto_en,
  input  logic [ADDR_W-1:0] auto_src,
`endif
  output logic              router_start_req,
  output logic [ADDR_W-1:0] router_scr_addr,
  output logic [ADDR_W-1:0] router_dst_addr,
  input  logic              router_done,
  output logic              busy,
  output logic              timeout_pulse,
  output logic [CNT_W-1:0]  done_cnt,
  output logic [CNT_W-1:0]  timeout_cnt
);

  localparam int TMR_W = cnt_w(TIMEOUT_CYC);
  localparam int GAP_W = cnt_w(GAP_CYC);

  rtr_req_state_t    state, state_nxt;
  logic [TMR_W-1:0]  tmr;
  logic [GAP_W-1:0]  gap_cnt;
  logic              launch_ok, accept, done_evt, to_evt, timer_hit, gap_last;
  logic [ADDR_W-1:0] src_sel, dst_sel;

`ifdef ROUTER_REQ_AUTO_EN
  logic [ADDR_W-1:0] sweep;
  assign src_sel = auto_en ? auto_src : cmd_src;
  assign dst_sel = auto_en ? sweep    : cmd_dst;
`else
  assign src_sel = cmd_src;
  assign dst_sel = cmd_dst;
`endif

  assign launch_ok = channel_up && !router_done && !reset;
  assign timer_hit = (TIMEOUT_CYC != 0) && (tmr == TMR_W'(TIMEOUT_CYC - 1));
  assign gap_last  = (gap_cnt == GAP_W'(GAP_CYC - 1));
  assign busy      = (state != IDLE);

  always_ff @(posedge user_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_nxt = state;
    cmd_ready = 1'b0;
    accept    = 1'b0;
    done_evt  = 1'b0;
    to_evt    = 1'b0;
    case (state)
      IDLE: begin
`ifdef ROUTER_REQ_AUTO_EN
        cmd_ready = launch_ok && !auto_en;
        accept    = launch_ok && (auto_en || cmd_valid);
`else
        cmd_ready = launch_ok;
        accept    = launch_ok && cmd_valid;
`endif
        if (accept) state_nxt = REQ;
      end
      REQ, WAIT_DONE: begin
        // Completion takes priority over both timeout and link loss.
        if (router_done) begin
          done_evt  = 1'b1;
          state_nxt = WAIT_LOW;
        end else if (!channel_up || timer_hit) begin
          to_evt    = 1'b1;
          state_nxt = WAIT_LOW;
        end else if (state == REQ) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_LOW: begin
        if (!router_done) state_nxt = (GAP_CYC == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (reset) begin
      router_start_req <= 1'b0;
      router_scr_addr  <= '0;
      router_dst_addr  <= '0;
      timeout_pulse    <= 1'b0;
      tmr              <= '0;
      gap_cnt          <= '0;
`ifdef ROUTER_REQ_AUTO_EN
      sweep            <= '0;
`endif
    end else begin
      timeout_pulse <= to_evt;
      if (accept) begin
        router_start_req <= 1'b1;
        router_scr_addr  <= src_sel;
        router_dst_addr  <= dst_sel;
      end
      if (done_evt || to_evt) router_start_req <= 1'b0;
      // Timer is zero in REQ and counts cycles the request has been high.
      if (state == REQ || state == WAIT_DONE) tmr <= tmr + 1'b1;
      else                                    tmr <= '0;
      if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
      else              gap_cnt <= '0;
`ifdef ROUTER_REQ_AUTO_EN
      if (done_evt || to_evt) sweep <= sweep + 1'b1;
`endif
    end
  end

  router_sat_cnt #(.W(CNT_W)) u_done_cnt (
    .user_clk (user_clk),
    .clr      (reset),
    .inc      (done_evt),
    .value    (done_cnt)
  );

  router_sat_cnt #(.W(CNT_W)) u_timeout_cnt (
    .user_clk (user_clk),
    .clr      (reset),
    .inc      (to_evt),
    .value    (timeout_cnt)
  );

endmodule

// File: tb/tb_router_req_gen.sv
// Self-checking bench for router_req_gen: directed scenarios plus randomized transactions.
module tb_router_req_gen;

  localparam int ADDR_W = 10;
  localparam int TO     = 100;
  localparam int GAPC   = 4;
  localparam int CW     = 4;
  localparam int CMAX   = (1 << CW) - 1;

  logic              user_clk = 1'b0;
  logic              reset = 1'b1;
  logic              channel_up = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_src = '0;
  logic [ADDR_W-1:0] cmd_dst = '0;
  logic              router_start_req;
  logic [ADDR_W-1:0] router_scr_addr;
  logic [ADDR_W-1:0] router_dst_addr;
  logic              router_done = 1'b0;
  logic              busy;
  logic              timeout_pulse;
  logic [CW-1:0]     done_cnt;
  logic [CW-1:0]     timeout_cnt;

  int checks = 0;
  int errors = 0;
  int done_exp = 0;
  int to_exp = 0;
  logic [ADDR_W-1:0] src_exp = '0;
  logic [ADDR_W-1:0] dst_exp = '0;

  router_req_gen #(
    .ADDR_W(ADDR_W), .TIMEOUT_CYC(TO), .GAP_CYC(GAPC), .CNT_W(CW)
  ) dut (
    .user_clk         (user_clk),
    .reset            (reset),
    .channel_up       (channel_up),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_src          (cmd_src),
    .cmd_dst          (cmd_dst),
    .router_start_req (router_start_req),
    .router_scr_addr  (router_scr_addr),
    .router_dst_addr  (router_dst_addr),
    .router_done      (router_done),
    .busy             (busy),
    .timeout_pulse    (timeout_pulse),
    .done_cnt         (done_cnt),
    .timeout_cnt      (timeout_cnt)
  );

  always #5 user_clk = ~user_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge user_clk);
    #1;
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start"},   router_start_req, 0);
    check({tag, "_src"},     router_scr_addr, 0);
    check({tag, "_dst"},     router_dst_addr, 0);
    check({tag, "_ready"},   cmd_ready, 0);
    check({tag, "_busy"},    busy, 0);
    check({tag, "_pulse"},   timeout_pulse, 0);
    check({tag, "_donecnt"}, done_cnt, 0);
    check({tag, "_tocnt"},   timeout_cnt, 0);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 200 && cmd_ready !== 1'b1; i++) step();
    check("wait_ready", cmd_ready, 1);
  endtask

  // One transaction. done_at: request-cycle index at which router_done is driven
  // high (-1 = never); drop_at: index at which channel_up is pulled low (-1 = never).
  // Index 0 is the first cycle router_start_req is high.
  task automatic run_txn(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst,
                         input int done_at, input int hold, input int drop_at);
    int other, end_c, fall_c, ready_c;
    bit is_done;
    other = TO - 1;
    if (drop_at >= 0 && drop_at < other) other = drop_at;
    is_done = (done_at >= 0) && (done_at <= other);
    end_c   = is_done ? done_at : other;
    fall_c  = is_done ? done_at + hold : end_c + 1;
    if (fall_c < end_c + 1) fall_c = end_c + 1;
    ready_c = fall_c + GAPC + 1;

    wait_ready();
    cmd_valid = 1'b1;
    cmd_src   = src;
    cmd_dst   = dst;
    src_exp   = src;
    dst_exp   = dst;
    step();
    for (int c = 0; c <= ready_c; c++) begin
      if (c == end_c + 1) begin
        if (is_done) done_exp = sat_inc(done_exp);
        else         to_exp   = sat_inc(to_exp);
      end
      check($sformatf("start_c%0d", c), router_start_req, (c <= end_c));
      check($sformatf("pulse_c%0d", c), timeout_pulse, (!is_done && c == end_c + 1));
      check($sformatf("busy_c%0d", c),  busy, (c < ready_c));
      check($sformatf("ready_c%0d", c), cmd_ready, (c == ready_c && drop_at < 0));
      check($sformatf("scr_c%0d", c),   router_scr_addr, src_exp);
      check($sformatf("dst_c%0d", c),   router_dst_addr, dst_exp);
      check($sformatf("donecnt_c%0d", c), done_cnt, done_exp);
      check($sformatf("tocnt_c%0d", c),   timeout_cnt, to_exp);
      cmd_valid   = (c == ready_c) ? 1'b0 : 1'($urandom);
      cmd_src     = ADDR_W'($urandom);
      cmd_dst     = ADDR_W'($urandom);
      router_done = is_done && (c >= done_at) && (c < done_at + hold);
      channel_up  = !(drop_at >= 0 && c >= drop_at);
      if (c < ready_c) step();
    end
    router_done = 1'b0;
    if (drop_at >= 0) begin
      step();
      check("drop_ready_low", cmd_ready, 0);
      channel_up = 1'b1;
      #1;
      check("drop_ready_back", cmd_ready, 1);
    end
  endtask

  initial begin
    // Reset behaviour
    channel_up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_reset_outputs("rst");
    end
    reset = 1'b0;
    step();
    check("idle_ready", cmd_ready, 1);
    check("idle_busy", busy, 0);
    router_done = 1'b1;
    #1;
    check("idle_ready_done_hi", cmd_ready, 0);
    router_done = 1'b0;
    channel_up  = 1'b0;
    #1;
    check("idle_ready_link_dn", cmd_ready, 0);
    channel_up = 1'b1;
    #1;
    check("idle_ready_link_up", cmd_ready, 1);

    // Nominal, timeout, simultaneous done/timeout, link drop
    run_txn(10'h005, 10'h2A3, 10, 3, -1);
    run_txn(10'h111, 10'h222, -1, 1, -1);
    run_txn(10'h0F0, 10'h30F, TO - 1, 2, -1);
    run_txn(10'h3FF, 10'h001, -1, 1, 6);

    // Reset in the middle of WAIT_DONE
    wait_ready();
    cmd_valid = 1'b1;
    cmd_src   = 10'h155;
    cmd_dst   = 10'h2AA;
    step();
    cmd_valid = 1'b0;
    check("mid_start", router_start_req, 1);
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1;
    step();
    done_exp = 0;
    to_exp   = 0;
    src_exp  = '0;
    dst_exp  = '0;
    check_reset_outputs("midrst1");
    step();
    check_reset_outputs("midrst2");
    reset = 1'b0;
    #1;
    check("post_rst_ready", cmd_ready, 1);

    // Randomized transactions; enough completions to saturate done_cnt
    for (int i = 0; i < 20; i++) begin
      if (i % 7 == 3)
        run_txn(ADDR_W'($urandom), ADDR_W'($urandom), -1, 1, -1);
      else
        run_txn(ADDR_W'($urandom), ADDR_W'($urandom),
                int'($urandom_range(40, 1)), int'($urandom_range(4, 1)), -1);
    end
    check("sat_done_cnt", done_cnt, CMAX);
    check("sat_to_cnt", timeout_cnt, to_exp);
    check("persist_scr", router_scr_addr, src_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
